var_delay_ctrl: RTL and testbench

//   Runtime-programmable delay line for the pixel/sync pipeline; replaces fixed-depth

---
 rtl/var_delay_ctrl_pkg.sv | 17 +
 rtl/var_delay_ctrl_ram.sv | 34 +++
 rtl/var_delay_ctrl.sv | 145 ++++++++++++++
 tb/tb_var_delay_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/var_delay_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : var_delay_ctrl_pkg
// Purpose : Shared types for the runtime-programmable delay line.
// Rev     : 1.0  initial release
// ============================================================================
package var_delay_ctrl_pkg;

  // FILL: line still collecting samples under the current delay, output masked.
  // RUN : line holds at least D valid samples, output follows the datapath.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } vdc_state_e;

endpackage : var_delay_ctrl_pkg
`default_nettype wire

// File: rtl/var_delay_ctrl_ram.sv
`default_nettype none
// ============================================================================
// Module  : var_delay_ctrl_ram
// Purpose : WIDTH x DEPTH simple dual-port storage, synchronous write,
//           combinational (asynchronous) read. Contents are not reset.
// Rev     : 1.0  initial release
// ============================================================================
module var_delay_ctrl_ram #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: one sample per enabled cycle.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port returns the contents before this cycle's write lands.
  assign rdata_o = mem_q[raddr_i];

endmodule : var_delay_ctrl_ram
`default_nettype wire

// File: rtl/var_delay_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : var_delay_ctrl
// Purpose : Runtime-programmable delay line (1..MAX_DELAY enabled cycles)
//           with FILL/RUN masking of the output after reset or reconfig.
// Rev     : 1.0  initial release
// ============================================================================
module var_delay_ctrl
  import var_delay_ctrl_pkg::*;
#(
  parameter int               WIDTH         = 24,
  parameter int               MAX_DELAY     = 64,
  parameter int               DEFAULT_DELAY = 2,
  parameter logic [WIDTH-1:0] IDLE_VAL      = '0,
  localparam int              AW            = $clog2(MAX_DELAY)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] d_o,
  output logic             vld_o,
  input  logic             cfg_we_i,
  input  logic [AW:0]      delay_i,
  output logic             cfg_busy_o,
  output logic             cfg_err_o
);

  localparam logic [AW:0] MAX_D = (AW+1)'(MAX_DELAY);
  localparam logic [AW:0] DEF_D = (AW+1)'(DEFAULT_DELAY);
  localparam logic [AW:0] ONE_D = (AW+1)'(1);

  vdc_state_e       state_q, state_d;
  logic [AW:0]      delay_q, delay_d;
  logic [AW:0]      fill_cnt_q, fill_cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;

  logic             w_accept;
  logic             w_legal;
  logic [AW:0]      w_delay_m1;
  logic [AW:0]      w_fill_inc;
  logic [AW-1:0]    w_rd_addr;
  logic [WIDTH-1:0] w_ram_rdata;
  logic [WIDTH-1:0] w_line_out;

  // Reconfiguration is only taken in RUN; FILL reports busy.
  assign w_accept   = cfg_we_i && (state_q == ST_RUN);
  assign w_legal    = (delay_i != '0) && (delay_i <= MAX_D);
  assign w_delay_m1 = delay_q - ONE_D;
  assign w_fill_inc = fill_cnt_q + ONE_D;
  // Oldest sample still inside the window; D-1 < MAX_DELAY so it is never
  // the slot being overwritten this cycle.
  assign w_rd_addr  = wr_ptr_q - w_delay_m1[AW-1:0];
  // D=1 is a single register stage, so it bypasses the RAM entirely.
  assign w_line_out = (delay_q == ONE_D) ? d_i : w_ram_rdata;
  assign wr_ptr_d   = en_i ? (wr_ptr_q + 1'b1) : wr_ptr_q;

  var_delay_ctrl_ram #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DELAY),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (en_i),
    .waddr_i (wr_ptr_q),
    .wdata_i (d_i),
    .raddr_i (w_rd_addr),
    .rdata_o (w_ram_rdata)
  );

  // Next-state: config accept, fill counting and output update on en_i.
  always_comb begin
    state_d    = state_q;
    delay_d    = delay_q;
    fill_cnt_d = fill_cnt_q;
    data_d     = data_q;
    vld_d      = vld_q;
    err_d      = err_q;

    if (w_accept && w_legal) begin
      // A same-cycle sample is the first one of the new fill.
      delay_d    = delay_i;
      err_d      = 1'b0;
      state_d    = ST_FILL;
      fill_cnt_d = '0;
      data_d     = IDLE_VAL;
      vld_d      = 1'b0;
      if (en_i) begin
        fill_cnt_d = ONE_D;
        if (delay_i == ONE_D) begin
          state_d = ST_RUN;
          data_d  = d_i;
          vld_d   = 1'b1;
        end
      end
    end else begin
      if (w_accept) begin
        err_d = 1'b1;
      end
      if (en_i) begin
        if (state_q == ST_FILL) begin
          fill_cnt_d = w_fill_inc;
          if (w_fill_inc == delay_q) begin
            state_d = ST_RUN;
            data_d  = w_line_out;
            vld_d   = 1'b1;
          end
        end else begin
          data_d = w_line_out;
        end
      end
    end
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_FILL;
      delay_q    <= DEF_D;
      fill_cnt_q <= '0;
      wr_ptr_q   <= '0;
      data_q     <= IDLE_VAL;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      delay_q    <= delay_d;
      fill_cnt_q <= fill_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      data_q     <= data_d;
      vld_q      <= vld_d;
      err_q      <= err_d;
    end
  end

  assign d_o        = data_q;
  assign vld_o      = vld_q;
  assign cfg_busy_o = (state_q == ST_FILL);
  assign cfg_err_o  = err_q;

endmodule : var_delay_ctrl
`default_nettype wire

// File: tb/tb_var_delay_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_var_delay_ctrl
// Purpose : Self-checking bench for var_delay_ctrl against a sample-history
//           reference model (delay counted in accepted samples).
// Rev     : 1.0  initial release
// ============================================================================
module tb_var_delay_ctrl;

  localparam int WIDTH = 24;
  localparam int MAXD  = 64;
  localparam int AW    = 6;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b1;
  logic             en_i = 1'b0;
  logic [WIDTH-1:0] d_i = '0;
  logic             cfg_we_i = 1'b0;
  logic [AW:0]      delay_i = '0;
  logic [WIDTH-1:0] d_o;
  logic             vld_o;
  logic             cfg_busy_o;
  logic             cfg_err_o;

  int checks = 0;
  int errors = 0;

  // Reference model: every enabled sample is appended to hist; m_n counts
  // samples since the last reset/legal reconfiguration. Output is valid once
  // at least m_d samples have arrived and then shows the sample m_d-1 back.
  logic [WIDTH-1:0] hist[$];
  int               m_d;
  int               m_n;
  logic [WIDTH-1:0] m_q;
  logic             m_v;
  logic             m_err;
  logic [WIDTH-1:0] ramp;

  var_delay_ctrl #(
    .WIDTH         (WIDTH),
    .MAX_DELAY     (MAXD),
    .DEFAULT_DELAY (2),
    .IDLE_VAL      ('0)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .d_i        (d_i),
    .d_o        (d_o),
    .vld_o      (vld_o),
    .cfg_we_i   (cfg_we_i),
    .delay_i    (delay_i),
    .cfg_busy_o (cfg_busy_o),
    .cfg_err_o  (cfg_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_d   = 2;
    m_n   = 0;
    m_q   = '0;
    m_v   = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".d_o"},  d_o, m_q);
    check({tag, ".vld"},  {{(WIDTH-1){1'b0}}, vld_o}, {{(WIDTH-1){1'b0}}, m_v});
    check({tag, ".busy"}, {{(WIDTH-1){1'b0}}, cfg_busy_o},
          {{(WIDTH-1){1'b0}}, (m_n < m_d)});
    check({tag, ".err"},  {{(WIDTH-1){1'b0}}, cfg_err_o}, {{(WIDTH-1){1'b0}}, m_err});
  endtask

  // One clock: drive inputs, advance the model with pre-edge state, check #1
  // after the edge.
  task automatic cyc(input logic en, input logic [WIDTH-1:0] d,
                     input logic we, input int dl, input string tag);
    en_i     = en;
    d_i      = d;
    cfg_we_i = we;
    delay_i  = (AW+1)'(dl);
    if (we && (m_n >= m_d)) begin
      if (dl >= 1 && dl <= MAXD) begin
        m_d   = dl;
        m_n   = 0;
        m_v   = 1'b0;
        m_q   = '0;
        m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
    if (en) begin
      hist.push_back(d);
      m_n++;
      if (m_n >= m_d) begin
        m_q = hist[hist.size() - m_d];
        m_v = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic ramp_run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, ramp, 1'b0, 0, tag);
      ramp++;
    end
  endtask

  initial begin
    model_reset();
    ramp = 24'h000000;

    // Reset state, reached without a clock edge.
    #1 rst_ni = 1'b0;
    #1;
    check_all("reset");
    @(posedge clk);
    #3 rst_ni = 1'b1;

    // T1: default delay 2, ramp input.
    ramp_run(20, "t1");

    // T2: delay 1 accepted with en_i low, then first enabled edge -> RUN.
    cyc(1'b0, 24'hABCDEF, 1'b1, 1, "t2.acc");
    check("t2.busy_after_acc", {{(WIDTH-1){1'b0}}, cfg_busy_o}, 24'h1);
    ramp_run(10, "t2");

    // T3: maximum delay over several pointer wraps.
    cyc(1'b1, ramp, 1'b1, 64, "t3.acc");
    ramp++;
    ramp_run(300, "t3");

    // T4: D=2 then reload 5 mid-stream; config requests during FILL ignored.
    cyc(1'b1, ramp, 1'b1, 2, "t4.acc2");
    ramp++;
    ramp_run(8, "t4.d2");
    cyc(1'b1, ramp, 1'b1, 5, "t4.acc5");
    ramp++;
    cyc(1'b1, ramp, 1'b1, 3, "t4.busy_we");
    ramp++;
    cyc(1'b0, ramp, 1'b1, 0, "t4.busy_bad");
    ramp_run(10, "t4.d5");

    // T5: illegal requests set the sticky error; legal request clears it.
    cyc(1'b1, ramp, 1'b1, 0, "t5.zero");
    ramp++;
    ramp_run(3, "t5.hold");
    cyc(1'b0, ramp, 1'b1, 65, "t5.over");
    ramp_run(3, "t5.hold2");
    cyc(1'b1, ramp, 1'b1, 3, "t5.legal");
    ramp++;
    ramp_run(6, "t5.d3");
    // Same delay requested again still refills.
    cyc(1'b1, ramp, 1'b1, 3, "t5.same");
    ramp++;
    ramp_run(5, "t5.refill");

    // T6: random enable and data, asynchronous reset mid-FILL.
    cyc(1'b0, '0, 1'b1, 8, "t6.acc8");
    for (int i = 0; i < 6; i++) begin
      cyc(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'b0, 0, "t6.fill");
    end
    #2 rst_ni = 1'b0;
    model_reset();
    #1;
    check_all("t6.async_rst");
    @(posedge clk);
    #1;
    check_all("t6.rst_held");
    #2 rst_ni = 1'b1;
    for (int i = 0; i < 600; i++) begin
      logic we;
      int   dl;
      we = ($urandom_range(0, 19) == 0);
      dl = $urandom_range(0, 70);
      if ($urandom_range(0, 3) != 0) dl = $urandom_range(1, 12);
      cyc(1'($urandom_range(0, 1)), WIDTH'($urandom), we, dl, "t6.rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_var_delay_ctrl
`default_nettype wire
